// File: rtl/branch_pkg.sv
// Shared types for the branch condition-flag generator: FSM state encoding
// and the packed condition-flag bundle.
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic V;
    logic C;
    logic N;
    logic Z;
    logic L;
  } flags_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit adder with carry in/out; one slice of the serial
// a + ~b + 1 subtraction.
module chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/branch_flag_gen.sv
// Multicycle a - b comparator producing V/C/N/Z/L branch flags, CHUNK bits
// per cycle through a single shared chunk adder.
module branch_flag_gen
  import branch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            V,
  output logic            C,
  output logic            N,
  output logic            Z,
  output logic            L
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (CHUNK < 1 || CHUNK > XLEN || (XLEN % CHUNK) != 0) begin : g_bad_param
      $error("branch_flag_gen: CHUNK must divide XLEN and lie in 1..XLEN");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  a_r;
  logic [XLEN-1:0]  nb_r;
  logic             carry;
  logic             zacc;
  flags_t           flags;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] nb_chunk;
  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             sum_zero;

  // Next-state and status decode
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Chunk select and shared adder stage
  assign last     = (cnt == CNT_W'(NCHUNK - 1));
  assign a_chunk  = a_r[cnt * CHUNK +: CHUNK];
  assign nb_chunk = nb_r[cnt * CHUNK +: CHUNK];
  assign sum_zero = (sum == '0);

  chunk_adder #(
    .W (CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk),
    .b    (nb_chunk),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == RUN) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // Operand and running-carry registers; always primed on accept, so no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r   <= a;
      nb_r  <= ~b;
      carry <= 1'b1;
      zacc  <= 1'b1;
    end else if (state == RUN) begin
      carry <= cout;
      zacc  <= zacc & sum_zero;
    end
  end

  // Flag register stage: the last chunk holds the operand sign bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (state == RUN && last) begin
      flags.C <= cout;
      flags.L <= ~cout;
      flags.Z <= zacc & sum_zero;
      flags.N <= sum[CHUNK-1];
      flags.V <= (a_r[XLEN-1] ^ ~nb_r[XLEN-1]) & (sum[CHUNK-1] ^ a_r[XLEN-1]);
    end
  end

  assign V = flags.V;
  assign C = flags.C;
  assign N = flags.N;
  assign Z = flags.Z;
  assign L = flags.L;

endmodule

// File: tb/tb_branch_flag_gen.sv
// Scoreboard bench for branch_flag_gen with CHUNK = 8, 1 and 32 instances.
module tb_branch_flag_gen;

  logic        clk = 1'b0;
  logic        rst_v   [3];
  logic        start_v [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [4:0]  fl_v    [3];

  int          nch [3] = '{4, 32, 1};
  int          cur = 0;
  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  logic [4:0]  last_flags [3] = '{5'd0, 5'd0, 5'd0};
  logic [4:0]  sb_q [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int CH = (k == 0) ? 8 : ((k == 1) ? 1 : 32);
    branch_flag_gen #(
      .XLEN  (32),
      .CHUNK (CH)
    ) u_dut (
      .clk   (clk),
      .rst   (rst_v[k]),
      .start (start_v[k]),
      .a     (a_v[k]),
      .b     (b_v[k]),
      .busy  (busy_v[k]),
      .done  (done_v[k]),
      .V     (fl_v[k][4]),
      .C     (fl_v[k][3]),
      .N     (fl_v[k][2]),
      .Z     (fl_v[k][1]),
      .L     (fl_v[k][0])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d got=0x%0h want=0x%0h", tag, cur, obs, exp);
    end
  endtask

  // Reference flags {V,C,N,Z,L} of a - b
  function automatic logic [4:0] ref_flags(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] d;
    logic        c, n, z, v;
    d = {1'b0, x} + {1'b0, ~y} + 33'd1;
    c = d[32];
    n = d[31];
    z = (d[31:0] == 32'd0);
    v = (x[31] != y[31]) && (n != x[31]);
    return {v, c, n, z, ~c};
  endfunction

  // Output monitor for the instance under test
  always @(negedge clk) begin
    if (rst_v[cur]) begin
      chk("rst_busy", {31'd0, busy_v[cur]}, 32'd0);
      chk("rst_done", {31'd0, done_v[cur]}, 32'd0);
      chk("rst_flags", {27'd0, fl_v[cur]}, 32'd0);
      busy_cnt = 0;
      last_flags[cur] = 5'd0;
    end else begin
      chk("busy_done_overlap", {31'd0, busy_v[cur] & done_v[cur]}, 32'd0);
      if (busy_v[cur]) begin
        busy_cnt++;
        chk("flag_hold", {27'd0, fl_v[cur]}, {27'd0, last_flags[cur]});
      end
      if (done_v[cur]) begin
        chk("busy_len", busy_cnt, nch[cur]);
        busy_cnt = 0;
        chk("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
        if (sb_q.size() > 0) begin
          last_flags[cur] = sb_q.pop_front();
          chk("flags", {27'd0, fl_v[cur]}, {27'd0, last_flags[cur]});
        end
        done_cnt++;
      end
    end
  end

  task automatic wait_done(input string tag);
    int c0;
    bit seen;
    c0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_op(input int k, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    a_v[k] = x; b_v[k] = y; start_v[k] = 1'b1;
    sb_q.push_back(ref_flags(x, y));
    @(posedge clk); #1;
    start_v[k] = 1'b0; a_v[k] = $urandom; b_v[k] = $urandom;
    wait_done("op");
  endtask

  task automatic quiet_check(input int k, input string tag);
    int c0;
    c0 = done_cnt;
    repeat (nch[k] + 3) @(posedge clk);
    #1;
    chk(tag, done_cnt - c0, 0);
    chk({tag, "_idle"}, {31'd0, busy_v[k]}, 32'd0);
  endtask

  task automatic midrun_start(input int k, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    a_v[k] = x; b_v[k] = y; start_v[k] = 1'b1;
    sb_q.push_back(ref_flags(x, y));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    @(posedge clk); #1;
    start_v[k] = 1'b1; a_v[k] = ~x; b_v[k] = x ^ y;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    wait_done("midrun");
    quiet_check(k, "midrun_no_extra_done");
  endtask

  task automatic back_to_back(input int k, input logic [31:0] x1, input logic [31:0] y1,
                              input logic [31:0] x2, input logic [31:0] y2);
    @(posedge clk); #1;
    a_v[k] = x1; b_v[k] = y1; start_v[k] = 1'b1;
    sb_q.push_back(ref_flags(x1, y1));
    @(posedge clk); #1;
    a_v[k] = x2; b_v[k] = y2;
    sb_q.push_back(ref_flags(x2, y2));
    wait_done("b2b_first");
    start_v[k] = 1'b0;
    wait_done("b2b_second");
    quiet_check(k, "b2b_no_third");
  endtask

  task automatic reset_midrun(input int k, input logic [31:0] x, input logic [31:0] y);
    int w;
    w = (nch[k] > 2) ? 2 : 0;
    @(posedge clk); #1;
    a_v[k] = x; b_v[k] = y; start_v[k] = 1'b1;
    sb_q.push_back(ref_flags(x, y));
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", {31'd0, busy_v[k]}, 32'd1);
    rst_v[k] = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy_v[k]}, 32'd0);
    chk("async_rst_done", {31'd0, done_v[k]}, 32'd0);
    chk("async_rst_flags", {27'd0, fl_v[k]}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_v[k] = 1'b0;
    quiet_check(k, "rst_no_done");
  endtask

  logic [31:0] dir_a [6] = '{32'd5, 32'h8000_0000, 32'd1, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] dir_b [6] = '{32'd5, 32'h0000_0001, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1; start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cur = k;
      chk("init_busy", {31'd0, busy_v[k]}, 32'd0);
      chk("init_done", {31'd0, done_v[k]}, 32'd0);
      chk("init_flags", {27'd0, fl_v[k]}, 32'd0);
    end
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cur = k;
      busy_cnt = 0;
      for (int i = 0; i < 6; i++) run_op(k, dir_a[i], dir_b[i]);
      for (int i = 0; i < 3; i++) begin
        logic [31:0] r;
        r = $urandom;
        run_op(k, r, (i == 0) ? r : $urandom);
      end
      if (nch[k] > 2) midrun_start(k, 32'd1, 32'd2);
      back_to_back(k, 32'd5, 32'd5, 32'd1, 32'd2);
      back_to_back(k, 32'h8000_0000, 32'd1, 32'd0, 32'hFFFF_FFFF);
      reset_midrun(k, 32'd9, 32'd3);
      run_op(k, 32'd3, 32'd9);
      run_op(k, 32'h1234_5678, 32'h1234_5678);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, fails);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/branch_flag_gen.md
# branch_flag_gen

Multicycle operand comparator that produces the V, C, N, Z, L condition flags consumed by the branch-decision logic. It takes two XLEN-bit register operands on a start pulse and computes a − b as a + ~b + 1, CHUNK bits per cycle, to keep the carry chain short. The flags are held stable until the next accepted start. It sits between the register-file read stage and the branch decision in the multicycle datapath.

## Interface
Parameters:
- XLEN, 32, operand width; XLEN % CHUNK == 0 required (elaboration error otherwise)
- CHUNK, 8, bits processed per cycle; 1 ≤ CHUNK ≤ XLEN

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a comparison; sampled only in IDLE or DONE
- a  input  XLEN  first operand (rs1); sampled when start is accepted
- b  input  XLEN  second operand (rs2); sampled when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; flags valid from this cycle onward
- V  output  1  signed overflow of a − b
- C  output  1  carry out of a + ~b + 1 (1 = no borrow, a ≥ b unsigned)
- N  output  1  MSB of a − b
- Z  output  1  a − b == 0
- L  output  1  a < b unsigned (L = ~C)

## Operation
- States:
  - IDLE: reset state.
  - RUN: processes one chunk per cycle.
  - DONE: lasts exactly one cycle.
- Transitions:
  - IDLE --start--> RUN
  - RUN --(last chunk)--> DONE
  - DONE --start--> RUN
  - DONE --!start--> IDLE
- Accepting start:
  - Latch a and ~b into working registers.
  - Set carry register to 1, chunk counter to 0, zero-accumulator to 1.
- Each RUN cycle:
  - Chunk i = bits [i·CHUNK +: CHUNK].
  - sum = a_i + nb_i + carry, producing CHUNK-bit result plus carry out.
  - carry ← carry out.
  - zero-acc ← zero-acc & (result == 0).
  - Counter increments.
- Last chunk (counter == XLEN/CHUNK − 1):
  - C ← carry out; L ← ~carry out.
  - Z ← zero-acc & (result == 0).
  - N ← result MSB.
  - V ← (a[XLEN−1] ≠ b[XLEN−1]) & (N ≠ a[XLEN−1]).
- Flag hold:
  - Flags are registered outputs and update only on the last-chunk edge.
  - Between updates they hold their values.
- Ignored inputs:
  - start in RUN is ignored; no queuing, and operands are not resampled.
  - Changes on a/b after acceptance have no effect.
- Counter width: $clog2(XLEN/CHUNK), minimum 1 bit; wraps to 0 on DONE entry.

## Timing
- Reset values: busy=0, done=0, V=C=N=Z=L=0, state IDLE.
- Latency, with start accepted at edge E0:
  - Chunks are processed on edges E1..E(XLEN/CHUNK).
  - Flags update and done rises on edge E(XLEN/CHUNK).
  - With defaults: 4 cycles from acceptance to done.
- busy is high from E0 until E(XLEN/CHUNK); done and busy are never high together.
- Back-to-back: start high during the DONE cycle is accepted, giving a throughput of one result per XLEN/CHUNK+1 cycles. Flags from the first op remain valid during the second op's RUN.
- CHUNK == XLEN: one RUN cycle; done one cycle after acceptance.
- Reset mid-RUN:
  - Immediately returns to IDLE and clears all flags and done.
  - No done pulse for the aborted op.
  - After deassertion the block is ready on the next edge.

## Structure
- Shared package branch_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} for state.
  - packed struct flags_t {V, C, N, Z, L}.
  - Default XLEN constant.
- One sub-module, chunk_adder: combinational CHUNK-bit adder with carry in/out. Instantiated once and fed by a mux on the counter.

## Test plan
- Equal operands: a=5, b=5, start → done after 4 cycles with Z=1, C=1, L=0, N=0, V=0; busy high for exactly 4 cycles.
- Signed overflow: a=0x80000000, b=0x00000001 → N=0, V=1, C=1, L=0, Z=0 (N^V=1, signed less-than).
- Negative result: a=1, b=2 → N=1, V=0, C=0, L=1, Z=0.
- Signed vs unsigned disagreement: a=0, b=0xFFFFFFFF → N=0, V=0, C=0, L=1.
- Back-to-back and ignored start:
  - Start held high continuously → second op accepted in the DONE cycle.
  - A start pulse mid-RUN changes nothing.
  - Flags stay at first-op values until the second done.
- Reset mid-RUN: assert rst at chunk 2 → busy, done and flags are 0 the same cycle and no done follows. A new op after release completes correctly. Repeat all cases with CHUNK=1 and CHUNK=32.
